// File: rtl/vdb_vga_pkg.sv
// Shared types and default timing for the VGA timing generator.
// Default timing is 640x480 with VESA-style porches and active-high syncs.
package vdb_vga_pkg;

   localparam logic [10:0] DEF_HOR_ACT   = 11'd640;
   localparam logic [7:0]  DEF_HOR_FP    = 8'd16;
   localparam logic [7:0]  DEF_HOR_SYNC  = 8'd96;
   localparam logic [7:0]  DEF_HOR_BP    = 8'd48;
   localparam logic [10:0] DEF_VERT_ACT  = 11'd480;
   localparam logic [7:0]  DEF_VERT_FP   = 8'd11;
   localparam logic [7:0]  DEF_VERT_SYNC = 8'd2;
   localparam logic [7:0]  DEF_VERT_BP   = 8'd31;
   localparam logic        DEF_SYNC_POL  = 1'b1;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      logic [10:0] act;
      logic [7:0]  fp;
      logic [7:0]  sync;
      logic [7:0]  bp;
   } axis_timing_t;

   typedef enum logic [1:0] {
      REG_SYNC,
      REG_BP,
      REG_ACTIVE,
      REG_FP
   } region_e;

   localparam axis_timing_t DEF_HOR_TIMING = '{
      act: DEF_HOR_ACT, fp: DEF_HOR_FP, sync: DEF_HOR_SYNC, bp: DEF_HOR_BP};
   localparam axis_timing_t DEF_VERT_TIMING = '{
      act: DEF_VERT_ACT, fp: DEF_VERT_FP, sync: DEF_VERT_SYNC, bp: DEF_VERT_BP};

   // Totals are 12 bit; configurations above 4095 are not supported.
   function automatic logic [11:0] axis_total(input axis_timing_t t);
      return {4'b0, t.sync} + {4'b0, t.bp} + {1'b0, t.act} + {4'b0, t.fp};
   endfunction

endpackage

// File: rtl/vdb_vga_axis_counter.sv
// One timing axis: position counter plus region decode (SYNC, BP, ACTIVE, FP).
// wrap_o is combinational and marks the increment that returns the count to 0.
module vdb_vga_axis_counter
   import vdb_vga_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  axis_timing_t timing_i,
   output logic [11:0]  count_o,
   output region_e      region_o,
   output logic         wrap_o
);

   logic [11:0] count_q, count_d;
   logic [11:0] total;
   logic [11:0] bp_start, act_start, fp_start;

   always_comb begin
      total   = axis_total(timing_i);
      wrap_o  = inc_i && (count_q == total - 12'd1);
      count_d = count_q;
      if (inc_i) begin
         count_d = wrap_o ? 12'd0 : count_q + 12'd1;
      end
   end

   // Region boundaries in order SYNC, BP, ACTIVE, FP; a zero porch collapses its region.
   always_comb begin
      bp_start  = {4'b0, timing_i.sync};
      act_start = bp_start + {4'b0, timing_i.bp};
      fp_start  = act_start + {1'b0, timing_i.act};
      if (count_q < bp_start) begin
         region_o = REG_SYNC;
      end else if (count_q < act_start) begin
         region_o = REG_BP;
      end else if (count_q < fp_start) begin
         region_o = REG_ACTIVE;
      end else begin
         region_o = REG_FP;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= 12'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/vdb_vga_timing_gen.sv
// VGA source: hsync/vsync/de/RGB from a pixel-stream handshake, with a shadow
// timing set that is copied into the active set only at the end of a frame.
module vdb_vga_timing_gen
   import vdb_vga_pkg::*;
#(
   parameter logic [10:0] HOR_ACT   = DEF_HOR_ACT,
   parameter logic [7:0]  HOR_FP    = DEF_HOR_FP,
   parameter logic [7:0]  HOR_SYNC  = DEF_HOR_SYNC,
   parameter logic [7:0]  HOR_BP    = DEF_HOR_BP,
   parameter logic [10:0] VERT_ACT  = DEF_VERT_ACT,
   parameter logic [7:0]  VERT_FP   = DEF_VERT_FP,
   parameter logic [7:0]  VERT_SYNC = DEF_VERT_SYNC,
   parameter logic [7:0]  VERT_BP   = DEF_VERT_BP,
   parameter logic        SYNC_POL  = DEF_SYNC_POL
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic        cfg_valid,
   input  logic [10:0] cfg_hact,
   input  logic [7:0]  cfg_hfp,
   input  logic [7:0]  cfg_hsync,
   input  logic [7:0]  cfg_hbp,
   input  logic [10:0] cfg_vact,
   input  logic [7:0]  cfg_vfp,
   input  logic [7:0]  cfg_vsync,
   input  logic [7:0]  cfg_vbp,
   output logic        cfg_pending,
   input  logic        pix_valid,
   input  logic [23:0] pix_rgb,
   output logic        pix_ready,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        frame_start,
   output logic        underflow
);

   localparam axis_timing_t HOR_DEF  = '{act: HOR_ACT, fp: HOR_FP, sync: HOR_SYNC, bp: HOR_BP};
   localparam axis_timing_t VERT_DEF = '{act: VERT_ACT, fp: VERT_FP, sync: VERT_SYNC, bp: VERT_BP};

   axis_timing_t hor_q, hor_d, vert_q, vert_d;
   axis_timing_t hor_sh_q, hor_sh_d, vert_sh_q, vert_sh_d;
   logic         pending_q, pending_d;

   logic [11:0]  h_count, v_count;
   region_e      h_region, v_region;
   logic         h_wrap, v_wrap;

   rgb_t         rgb_q, rgb_d;
   logic         hsync_q, hsync_d, vsync_q, vsync_d;
   logic         de_q, de_d, fs_q, fs_d, uf_q, uf_d;

   vdb_vga_axis_counter u_hor (
      .clk_i    (pixel_clk),
      .rst_i    (rst),
      .inc_i    (1'b1),
      .timing_i (hor_q),
      .count_o  (h_count),
      .region_o (h_region),
      .wrap_o   (h_wrap)
   );

   vdb_vga_axis_counter u_vert (
      .clk_i    (pixel_clk),
      .rst_i    (rst),
      .inc_i    (h_wrap),
      .timing_i (vert_q),
      .count_o  (v_count),
      .region_o (v_region),
      .wrap_o   (v_wrap)
   );

   // v_wrap only fires on the last pixel of the last line, i.e. the frame boundary.
   // A write landing on the boundary goes to the shadow after the old shadow is applied.
   always_comb begin
      hor_d     = hor_q;
      vert_d    = vert_q;
      hor_sh_d  = hor_sh_q;
      vert_sh_d = vert_sh_q;
      pending_d = pending_q;
      if (v_wrap && pending_q) begin
         hor_d     = hor_sh_q;
         vert_d    = vert_sh_q;
         pending_d = 1'b0;
      end
      if (cfg_valid) begin
         hor_sh_d  = '{act: cfg_hact, fp: cfg_hfp, sync: cfg_hsync, bp: cfg_hbp};
         vert_sh_d = '{act: cfg_vact, fp: cfg_vfp, sync: cfg_vsync, bp: cfg_vbp};
         pending_d = 1'b1;
      end
   end

   always_comb begin
      pix_ready = ~rst && (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
      hsync_d   = (h_region == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d   = (v_region == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
      de_d      = pix_ready;
      rgb_d     = (pix_ready && pix_valid) ? rgb_t'(pix_rgb) : '0;
      uf_d      = uf_q | (pix_ready & ~pix_valid);
      fs_d      = (h_count == 12'd0) && (v_count == 12'd0);
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         hor_q     <= HOR_DEF;
         vert_q    <= VERT_DEF;
         hor_sh_q  <= HOR_DEF;
         vert_sh_q <= VERT_DEF;
         pending_q <= 1'b0;
         hsync_q   <= ~SYNC_POL;
         vsync_q   <= ~SYNC_POL;
         de_q      <= 1'b0;
         rgb_q     <= '0;
         fs_q      <= 1'b0;
         uf_q      <= 1'b0;
      end else begin
         hor_q     <= hor_d;
         vert_q    <= vert_d;
         hor_sh_q  <= hor_sh_d;
         vert_sh_q <= vert_sh_d;
         pending_q <= pending_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         de_q      <= de_d;
         rgb_q     <= rgb_d;
         fs_q      <= fs_d;
         uf_q      <= uf_d;
      end
   end

   assign cfg_pending = pending_q;
   assign r           = rgb_q.r;
   assign g           = rgb_q.g;
   assign b           = rgb_q.b;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign frame_start = fs_q;
   assign underflow   = uf_q;

endmodule

// File: tb/tb_vdb_vga_timing_gen.sv
// Bench for vdb_vga_timing_gen: frame-position model checked every cycle plus
// hand-computed timing pins. Vertical defaults are shortened so whole frames fit.
module tb_vdb_vga_timing_gen;

   logic        pixel_clk;
   logic        rst;
   logic        cfg_valid;
   logic [10:0] cfg_hact, cfg_vact;
   logic [7:0]  cfg_hfp, cfg_hsync, cfg_hbp, cfg_vfp, cfg_vsync, cfg_vbp;
   logic        cfg_pending;
   logic        pix_valid;
   logic [23:0] pix_rgb;
   logic        pix_ready;
   logic [7:0]  r, g, b;
   logic        hsync, vsync, de, frame_start, underflow;

   // order: hact, hfp, hsync, hbp, vact, vfp, vsync, vbp
   localparam int DEF_T [8] = '{640, 16, 96, 48, 6, 1, 2, 3};

   vdb_vga_timing_gen #(
      .VERT_ACT  (11'd6),
      .VERT_FP   (8'd1),
      .VERT_SYNC (8'd2),
      .VERT_BP   (8'd3)
   ) u_dut (
      .pixel_clk   (pixel_clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_hact    (cfg_hact),
      .cfg_hfp     (cfg_hfp),
      .cfg_hsync   (cfg_hsync),
      .cfg_hbp     (cfg_hbp),
      .cfg_vact    (cfg_vact),
      .cfg_vfp     (cfg_vfp),
      .cfg_vsync   (cfg_vsync),
      .cfg_vbp     (cfg_vbp),
      .cfg_pending (cfg_pending),
      .pix_valid   (pix_valid),
      .pix_rgb     (pix_rgb),
      .pix_ready   (pix_ready),
      .r           (r),
      .g           (g),
      .b           (b),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .frame_start (frame_start),
      .underflow   (underflow)
   );

   // clock
   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic report();
      $display("%0d/%0d checks passed", n_pass, n_chk);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, got, got, exp, exp, $time);
         if (n_fail >= 40) begin
            report();
            $finish;
         end
      end
   endtask

   // model: position within the frame as a single index, decoded by div/mod
   int  m_t = 0;
   int  m_cur [8] = DEF_T;
   int  m_sh  [8] = DEF_T;
   bit  m_pend = 0;
   bit  m_uf = 0;
   bit  e_hs, e_vs, e_de, e_fs;
   logic [23:0] e_rgb;

   function automatic bit in_active(input int c, input int act, input int sync, input int bp);
      return (c >= sync + bp) && (c < sync + bp + act);
   endfunction

   function automatic bit model_active(input int t);
      int htot;
      htot = m_cur[0] + m_cur[1] + m_cur[2] + m_cur[3];
      return in_active(t % htot, m_cur[0], m_cur[2], m_cur[3]) &&
             in_active(t / htot, m_cur[4], m_cur[6], m_cur[7]);
   endfunction

   always @(posedge pixel_clk) begin
      int htot, vtot, h, v;
      bit act;
      if (rst) begin
         e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_rgb = '0;
         m_uf = 0; m_t = 0; m_cur = DEF_T; m_sh = DEF_T; m_pend = 0;
      end else begin
         htot  = m_cur[0] + m_cur[1] + m_cur[2] + m_cur[3];
         vtot  = m_cur[4] + m_cur[5] + m_cur[6] + m_cur[7];
         h     = m_t % htot;
         v     = m_t / htot;
         act   = model_active(m_t);
         e_hs  = (h < m_cur[2]);
         e_vs  = (v < m_cur[6]);
         e_de  = act;
         e_rgb = (act && pix_valid) ? pix_rgb : 24'd0;
         if (act && !pix_valid) m_uf = 1;
         e_fs  = (m_t == 0);
         if (m_t == htot * vtot - 1) begin
            m_t = 0;
            if (m_pend) begin
               m_cur  = m_sh;
               m_pend = 0;
            end
         end else begin
            m_t++;
         end
         if (cfg_valid) begin
            m_sh   = '{int'(cfg_hact), int'(cfg_hfp), int'(cfg_hsync), int'(cfg_hbp),
                       int'(cfg_vact), int'(cfg_vfp), int'(cfg_vsync), int'(cfg_vbp)};
            m_pend = 1;
         end
      end
      #2;
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("de", 32'(de), 32'(e_de));
      chk("rgb", 32'({r, g, b}), 32'(e_rgb));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
      chk("pix_ready", 32'(pix_ready), 32'(!rst && model_active(m_t)));
   end

   // driver state and measurements taken one step at a time
   int rel = 0;
   int hs_cnt, vs_cnt, first_rdy, de_run;
   bit hs_prev;
   int fs_q[$], hr_q[$], de_runs[$];

   task automatic step();
      @(posedge pixel_clk);
      #1;
      rel++;
      if (rel <= 800 && hsync) hs_cnt++;
      if (rel <= 9600 && vsync) vs_cnt++;
      if (frame_start) fs_q.push_back(rel);
      if (hsync && !hs_prev) hr_q.push_back(rel);
      hs_prev = hsync;
      if (pix_ready && first_rdy < 0) first_rdy = rel;
      if (de) begin
         de_run++;
      end else begin
         if (de_run > 0) de_runs.push_back(de_run);
         de_run = 0;
      end
      pix_rgb = pix_rgb + 24'h010203;
   endtask

   task automatic run_to(input int n);
      while (rel < n) step();
   endtask

   task automatic cfg_write(input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb);
      cfg_hact = 11'(ha); cfg_hfp = 8'(hf); cfg_hsync = 8'(hs); cfg_hbp = 8'(hb);
      cfg_vact = 11'(va); cfg_vfp = 8'(vf); cfg_vsync = 8'(vs); cfg_vbp = 8'(vb);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_hsync"}, 32'(hsync), 32'd0);
      chk({tag, "_vsync"}, 32'(vsync), 32'd0);
      chk({tag, "_de"}, 32'(de), 32'd0);
      chk({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
      chk({tag, "_fs"}, 32'(frame_start), 32'd0);
      chk({tag, "_uf"}, 32'(underflow), 32'd0);
      chk({tag, "_pending"}, 32'(cfg_pending), 32'd0);
      chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; pix_valid = 1'b0; pix_rgb = 24'h0;
      cfg_hact = '0; cfg_hfp = '0; cfg_hsync = '0; cfg_hbp = '0;
      cfg_vact = '0; cfg_vfp = '0; cfg_vsync = '0; cfg_vbp = '0;
      hs_cnt = 0; vs_cnt = 0; first_rdy = -1; de_run = 0; hs_prev = 0;
      repeat (3) step();
      chk_reset_values("reset");

      rst = 1'b0; pix_valid = 1'b1; rel = 0;
      run_to(5244);
      chk("uf_before_drop", 32'(underflow), 32'd0);
      pix_valid = 1'b0;
      repeat (3) step();
      chk("drop_rgb", 32'({r, g, b}), 32'd0);
      chk("drop_de", 32'(de), 32'd1);
      chk("drop_uf", 32'(underflow), 32'd1);
      pix_valid = 1'b1;

      run_to(6000);
      cfg_write(800, 40, 128, 88, 2, 1, 4, 23);
      chk("pend_mid_frame", 32'(cfg_pending), 32'd1);
      run_to(9601);
      chk("pend_applied", 32'(cfg_pending), 32'd0);

      run_to(20000);
      cfg_write(12, 1, 2, 2, 3, 1, 1, 1);
      run_to(41279);
      cfg_write(20, 2, 3, 4, 4, 1, 1, 1);
      chk("pend_on_boundary", 32'(cfg_pending), 32'd1);
      step();
      chk("pend_across", 32'(cfg_pending), 32'd1);
      chk("fs_after_boundary", 32'(frame_start), 32'd1);
      run_to(41586);
      chk("pend_late_applied", 32'(cfg_pending), 32'd0);
      run_to(41600);

      chk("hsync_width", 32'(hs_cnt), 32'd96);
      chk("vsync_width", 32'(vs_cnt), 32'd1600);
      chk("first_ready", 32'(first_rdy), 32'd4144);
      chk("underflow_sticky", 32'(underflow), 32'd1);
      chk("de_run_count", 32'(de_runs.size() >= 6), 32'd1);
      if (de_runs.size() >= 6) begin
         chk("de_run_first", 32'(de_runs[0]), 32'd640);
         chk("de_run_underflow_line", 32'(de_runs[1]), 32'd640);
         chk("de_run_last", 32'(de_runs[5]), 32'd640);
      end
      chk("hrise_count", 32'(hr_q.size() >= 14), 32'd1);
      if (hr_q.size() >= 14) begin
         chk("line_len_underflow", 32'(hr_q[7] - hr_q[6]), 32'd800);
         chk("line_len_new", 32'(hr_q[13] - hr_q[12]), 32'd1056);
      end
      chk("fs_count", 32'(fs_q.size()), 32'd5);
      if (fs_q.size() >= 5) begin
         chk("fs_first", 32'(fs_q[0]), 32'd1);
         chk("frame0_len", 32'(fs_q[1] - fs_q[0]), 32'd9600);
         chk("frame1_len", 32'(fs_q[2] - fs_q[1]), 32'd31680);
         chk("frame2_len", 32'(fs_q[3] - fs_q[2]), 32'd102);
         chk("frame3_len", 32'(fs_q[4] - fs_q[3]), 32'd203);
      end

      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0; rel = 0; first_rdy = -1;
      run_to(1000);
      cfg_write(12, 1, 2, 2, 3, 1, 1, 1);
      chk("pend_before_rst", 32'(cfg_pending), 32'd1);
      run_to(2700);
      rst = 1'b1;
      step();
      chk_reset_values("mid_rst");
      rst = 1'b0; rel = 0; first_rdy = -1;
      step();
      chk("restart_fs", 32'(frame_start), 32'd1);
      chk("restart_hsync", 32'(hsync), 32'd1);
      run_to(4200);
      chk("restart_first_ready", 32'(first_rdy), 32'd4144);
      chk("restart_uf", 32'(underflow), 32'd0);

      report();
      $finish;
   end

endmodule
